// File: rtl/filter_pkg.sv
// Shared types and width helpers for the multi-channel moving-average filter.
package filter_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, ACCUM, EMIT} state_t;

  function automatic int sum_width(input int data_w, input int depth_log2);
    return data_w + depth_log2;
  endfunction

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/filter_sample_ram.sv
// Single-port synchronous sample history RAM, registered read, no reset so it maps to block RAM.
module filter_sample_ram #(
  parameter int DATA_W = 10,
  parameter int AW     = 10,
  parameter int WORDS  = 1024
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/moving_average_filter_mc.sv
// Time-multiplexed boxcar filter: per-channel running sum over a circular history
// in shared RAM; one sample per four cycles, result is sum >>> DEPTH_LOG2.
module moving_average_filter_mc
  import filter_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 8,
  parameter int CHANNELS   = 4,
  parameter int PRIME_MODE = 0,
  localparam int CH_W      = ch_width(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_chan,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  input  logic [CH_W-1:0]          flush_chan,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_chan,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CHANNELS-1:0]      primed
);

  localparam int SUM_W = sum_width(DATA_W, DEPTH_LOG2);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = CH_W + DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CH_W:0]    CH_LIM = (CH_W+1)'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_t state, state_nx;

  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] data_q;
  logic                     ch_ok;

  logic signed [SUM_W-1:0]  sum_r  [CHANNELS];
  logic [DEPTH_LOG2-1:0]    wr_ptr [CHANNELS];
  logic [CNT_W-1:0]         cnt    [CHANNELS];

  logic                     in_ok, flush_ok, accept, do_flush, emit;
  logic                     ram_en, ram_we;
  logic [AW-1:0]            ram_addr;
  logic signed [DATA_W-1:0] ram_rdata, oldest;
  logic signed [SUM_W-1:0]  sum_nx;
  logic [CNT_W-1:0]         cnt_nx;

  // Out-of-range channels still walk the FSM but touch no state.
  assign in_ok    = {1'b0, in_chan}    < CH_LIM;
  assign flush_ok = {1'b0, flush_chan} < CH_LIM;
  assign accept   = in_valid & in_ready;
  assign do_flush = (state == IDLE) & flush;

  filter_sample_ram #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .WORDS  (CHANNELS * DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = FETCH;
      FETCH:   state_nx = ACCUM;
      ACCUM:   state_nx = EMIT;
      EMIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = reset_n & (state == IDLE) & ~flush;
    ram_we   = (state == ACCUM);
    ram_en   = ram_we ? ch_ok : (accept & in_ok);
    ram_addr = ram_we ? {ch_q, wr_ptr[ch_q]} : {in_chan, wr_ptr[in_chan]};
  end

  // The oldest sample only leaves the window once the history is full.
  always_comb begin
    oldest = (cnt[ch_q] == CNT_FULL) ? ram_rdata : '0;
    sum_nx = sum_r[ch_q] + SUM_W'(data_q) - SUM_W'(oldest);
    cnt_nx = (cnt[ch_q] == CNT_FULL) ? cnt[ch_q] : cnt[ch_q] + 1'b1;
    emit   = ch_ok & ((PRIME_MODE == 0) | primed[ch_q]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q      <= '0;
      data_q    <= '0;
      ch_ok     <= 1'b0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      primed    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_r[c]  <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        ch_q   <= in_chan;
        data_q <= in_data;
        ch_ok  <= in_ok;
      end
      if (do_flush && flush_ok) begin
        sum_r[flush_chan]  <= '0;
        cnt[flush_chan]    <= '0;
        wr_ptr[flush_chan] <= '0;
        primed[flush_chan] <= 1'b0;
      end
      if (state == ACCUM && ch_ok) begin
        sum_r[ch_q]  <= sum_nx;
        wr_ptr[ch_q] <= wr_ptr[ch_q] + 1'b1;
        cnt[ch_q]    <= cnt_nx;
        if (cnt_nx == CNT_FULL) primed[ch_q] <= 1'b1;
      end
      if (state == EMIT && emit) begin
        out_valid <= 1'b1;
        out_chan  <= ch_q;
        out_data  <= DATA_W'(sum_r[ch_q] >>> DEPTH_LOG2);
      end
    end
  end

endmodule
